// File: rtl/reg_gpio_pkg.sv
// Shared definitions for the reg_gpio register responder.
//  - Word offsets of every register in the window (byte address >> 2).
//  - Handshake FSM state encoding.
//  - Bitfield positions inside CFG and IRQ_EN / IRQ_STAT.
//  - Helper that packs rise/fall vectors into the IRQ register layout.
package rw_gpio_pkg;

    localparam int GPIO_OUT_W = 8;
    localparam int GPIO_IN_W  = 16;

    // Word offsets (byte offset / 4)
    localparam logic [2:0] OFF_OUT      = 3'd0;
    localparam logic [2:0] OFF_IN       = 3'd1;
    localparam logic [2:0] OFF_CFG      = 3'd2;
    localparam logic [2:0] OFF_IRQ_EN   = 3'd3;
    localparam logic [2:0] OFF_IRQ_STAT = 3'd4;
    localparam logic [2:0] OFF_OUT_SET  = 3'd5;
    localparam logic [2:0] OFF_OUT_CLR  = 3'd6;

    // CFG fields
    localparam int CFG_DFLT_LSB   = 0;
    localparam int CFG_REFCLK_LSB = 8;

    // IRQ_EN / IRQ_STAT fields
    localparam int IRQ_RISE_LSB = 0;
    localparam int IRQ_FALL_LSB = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_t;

    // Rise flags in the low half, fall flags in the high half.
    function automatic logic [31:0] pack_irq(input logic [GPIO_IN_W-1:0] rise,
                                             input logic [GPIO_IN_W-1:0] fall);
        logic [31:0] v;
        v = '0;
        v[IRQ_RISE_LSB +: GPIO_IN_W] = rise;
        v[IRQ_FALL_LSB +: GPIO_IN_W] = fall;
        return v;
    endfunction

endpackage

// File: rtl/reg_gpio_if.sv
// CPU-side register bus for reg_gpio.
// Handshake: the master raises bus_sel with bus_we/bus_addr/bus_wdata valid and
// holds them until bus_ready; the slave pulses bus_ready for exactly one cycle,
// with bus_rdata valid in that cycle; the master drops bus_sel in the cycle
// after bus_ready, or keeps it high to start the next access.
interface reg_gpio_if #(
    parameter int ADDR_W = 5
);
    logic              bus_sel;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ready;

    modport master (
        output bus_sel, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_sel, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/reg_gpio_edge_det.sv
// gpio_edge_det: registers the input vector once per cycle and produces
// single-cycle rise/fall strobes per bit.
// Ports:
//  clk, rst  clock and asynchronous active-high reset
//  gpio_in   input vector (already filtered upstream)
//  rise      gpio_in & ~gpio_in_d
//  fall      ~gpio_in & gpio_in_d
module gpio_edge_det #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    logic [WIDTH-1:0] gpio_in_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_in_d <= '0;
        end else begin
            gpio_in_d <= gpio_in;
        end
    end

    assign rise = gpio_in  & ~gpio_in_d;
    assign fall = ~gpio_in & gpio_in_d;
endmodule

// File: rtl/reg_gpio.sv
// reg_gpio: bus-side register responder for fnc_gpio.
// Decodes CPU accesses into OUT / IN / CFG / IRQ_EN / IRQ_STAT / OUT_SET /
// OUT_CLR, latches enabled gpio_in edges as sticky interrupt status and
// drives irq as the OR of that status.
// Ports:
//  clk, rst    clock, asynchronous active-high reset
//  bus         reg_gpio_if slave (sel/we/addr/wdata in, rdata/ready out)
//  gpio_out    output state to fnc_gpio
//  gpio_in     filtered input state from fnc_gpio
//  dflt_st     digital filter setting (CFG[7:0])
//  refclk_st   divided-clock setting (CFG[15:8])
//  irq         level interrupt, |IRQ_STAT
//  dbg_state   handshake FSM state
module reg_gpio
    import rw_gpio_pkg::*;
#(
    parameter int          ADDR_W     = 5,
    parameter logic [7:0]  DFLT_RST   = 8'd5,
    parameter logic [7:0]  REFCLK_RST = 8'd2
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_gpio_if.slave             bus,
    output logic [GPIO_OUT_W-1:0] gpio_out,
    input  logic [GPIO_IN_W-1:0]  gpio_in,
    output logic [7:0]            dflt_st,
    output logic [7:0]            refclk_st,
    output logic                  irq,
    output bus_state_t            dbg_state
);
    bus_state_t state_q, state_nxt;

    logic [GPIO_OUT_W-1:0] out_q, out_nxt;
    logic [7:0]            dflt_q, dflt_nxt;
    logic [7:0]            refclk_q, refclk_nxt;
    logic [31:0]           irq_en_q, irq_en_nxt;
    logic [31:0]           irq_stat_q, irq_stat_nxt;
    logic [31:0]           w1c_mask;
    logic [31:0]           set_vec;
    logic [31:0]           rdata_q, rdata_mux;
    logic [GPIO_IN_W-1:0]  rise, fall;
    logic                  access;
    logic [ADDR_W-3:0]     word_idx;
    logic                  unused_addr_lsb;

    // Byte-lane bits of the address carry no information here.
    assign unused_addr_lsb = ^bus.bus_addr[1:0];
    assign word_idx        = bus.bus_addr[ADDR_W-1:2];

    // An access is accepted on the edge that leaves IDLE with sel high; all
    // write effects and the read sample happen on that same edge.
    assign access = (state_q == ST_IDLE) && bus.bus_sel;

    gpio_edge_det #(.WIDTH(GPIO_IN_W)) u_edge_det (
        .clk     (clk),
        .rst     (rst),
        .gpio_in (gpio_in),
        .rise    (rise),
        .fall    (fall)
    );

    // Handshake FSM next state
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (bus.bus_sel) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Register write decode and interrupt status update
    always_comb begin
        out_nxt    = out_q;
        dflt_nxt   = dflt_q;
        refclk_nxt = refclk_q;
        irq_en_nxt = irq_en_q;
        w1c_mask   = '0;
        if (access && bus.bus_we) begin
            case (word_idx)
                (ADDR_W-2)'(OFF_OUT):      out_nxt    = bus.bus_wdata[GPIO_OUT_W-1:0];
                (ADDR_W-2)'(OFF_CFG): begin
                    dflt_nxt   = bus.bus_wdata[CFG_DFLT_LSB +: 8];
                    refclk_nxt = bus.bus_wdata[CFG_REFCLK_LSB +: 8];
                end
                (ADDR_W-2)'(OFF_IRQ_EN):   irq_en_nxt = bus.bus_wdata;
                (ADDR_W-2)'(OFF_IRQ_STAT): w1c_mask   = bus.bus_wdata;
                (ADDR_W-2)'(OFF_OUT_SET):  out_nxt    = out_q | bus.bus_wdata[GPIO_OUT_W-1:0];
                (ADDR_W-2)'(OFF_OUT_CLR):  out_nxt    = out_q & ~bus.bus_wdata[GPIO_OUT_W-1:0];
                default: ;
            endcase
        end
        // Enable is qualified in the same cycle as the edge; a new event on a
        // bit being cleared wins over the clear.
        set_vec      = pack_irq(rise, fall) & irq_en_q;
        irq_stat_nxt = (irq_stat_q & ~w1c_mask) | set_vec;
    end

    // Read mux; reserved and write-only locations read as zero.
    always_comb begin
        rdata_mux = '0;
        case (word_idx)
            (ADDR_W-2)'(OFF_OUT):      rdata_mux[GPIO_OUT_W-1:0] = out_q;
            (ADDR_W-2)'(OFF_IN):       rdata_mux[GPIO_IN_W-1:0]  = gpio_in;
            (ADDR_W-2)'(OFF_CFG): begin
                rdata_mux[CFG_DFLT_LSB +: 8]   = dflt_q;
                rdata_mux[CFG_REFCLK_LSB +: 8] = refclk_q;
            end
            (ADDR_W-2)'(OFF_IRQ_EN):   rdata_mux = irq_en_q;
            (ADDR_W-2)'(OFF_IRQ_STAT): rdata_mux = irq_stat_q;
            default:                   rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            out_q      <= '0;
            dflt_q     <= DFLT_RST;
            refclk_q   <= REFCLK_RST;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_nxt;
            out_q      <= out_nxt;
            dflt_q     <= dflt_nxt;
            refclk_q   <= refclk_nxt;
            irq_en_q   <= irq_en_nxt;
            irq_stat_q <= irq_stat_nxt;
            if (access) begin
                rdata_q <= rdata_mux;
            end
        end
    end

    // ready is decoded from state so an asynchronous reset drops it at once.
    assign bus.bus_ready = (state_q == ST_RESP);
    assign bus.bus_rdata = rdata_q;
    assign gpio_out      = out_q;
    assign dflt_st       = dflt_q;
    assign refclk_st     = refclk_q;
    assign irq           = |irq_stat_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_reg_gpio.sv
module tb_reg_gpio;
  import rw_gpio_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  gpio_out;
  logic [15:0] gpio_in;
  logic [7:0]  dflt_st;
  logic [7:0]  refclk_st;
  logic        irq;
  bus_state_t  dbg_state;
  logic [31:0] rd;

  int vectors;
  int miscompares;

  reg_gpio_if #(.ADDR_W(5)) bus_if ();

  reg_gpio #(.ADDR_W(5), .DFLT_RST(8'd5), .REFCLK_RST(8'd2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .gpio_out  (gpio_out),
    .gpio_in   (gpio_in),
    .dflt_st   (dflt_st),
    .refclk_st (refclk_st),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // drivers: inputs change on negedge, outputs sampled on negedge
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = a; bus_if.bus_wdata = d;
    @(negedge clk);
    check("wr_ready", {31'd0, bus_if.bus_ready}, 32'd1);
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = a; bus_if.bus_wdata = '0;
    @(negedge clk);
    check("rd_ready", {31'd0, bus_if.bus_ready}, 32'd1);
    d = bus_if.bus_rdata;
    bus_if.bus_sel = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    gpio_in = '0;
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0; bus_if.bus_addr = '0; bus_if.bus_wdata = '0;

    // reset state
    #12;
    check("rst_gpio_out", {24'd0, gpio_out}, 32'h0);
    check("rst_dflt", {24'd0, dflt_st}, 32'd5);
    check("rst_refclk", {24'd0, refclk_st}, 32'd2);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ready", {31'd0, bus_if.bus_ready}, 32'd0);
    check("rst_rdata", bus_if.bus_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // OUT write / read, SET, CLR
    bus_write(5'h00, 32'h0000_0055);
    bus_read(5'h00, rd);
    check("out_rd", rd, 32'h0000_0055);
    check("out_pin", {24'd0, gpio_out}, 32'h55);
    bus_write(5'h14, 32'h0000_00A0);
    check("out_set", {24'd0, gpio_out}, 32'hF5);
    bus_write(5'h18, 32'h0000_0005);
    check("out_clr", {24'd0, gpio_out}, 32'hF0);
    bus_read(5'h14, rd);
    check("out_set_rd0", rd, 32'h0);

    // IN
    gpio_in = 16'hAAAA;
    bus_read(5'h04, rd);
    check("in_rd", rd, 32'h0000_AAAA);

    // CFG
    bus_write(5'h08, 32'h0000_0309);
    check("cfg_dflt", {24'd0, dflt_st}, 32'd9);
    check("cfg_refclk", {24'd0, refclk_st}, 32'd3);
    bus_read(5'h08, rd);
    check("cfg_rd", rd, 32'h0000_0309);

    // unmapped
    bus_write(5'h1C, 32'hFFFF_FFFF);
    bus_read(5'h1C, rd);
    check("unmap_rd", rd, 32'h0);
    check("unmap_out", {24'd0, gpio_out}, 32'hF0);
    check("unmap_cfg", {16'd0, refclk_st, dflt_st}, 32'h0309);

    // handshake: sel for one cycle
    @(negedge clk);
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b0; bus_if.bus_addr = 5'h00;
    check("hs_idle_ready", {31'd0, bus_if.bus_ready}, 32'd0);
    @(negedge clk);
    check("hs_ready_hi", {31'd0, bus_if.bus_ready}, 32'd1);
    check("hs_rdata", bus_if.bus_rdata, 32'h0000_00F0);
    bus_if.bus_sel = 1'b0;
    @(negedge clk);
    check("hs_ready_lo", {31'd0, bus_if.bus_ready}, 32'd0);

    // back-to-back writes, sel held high: 4 cycles
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = 5'h00; bus_if.bus_wdata = 32'h11;
    @(negedge clk);
    check("b2b_ready1", {31'd0, bus_if.bus_ready}, 32'd1);
    check("b2b_out1", {24'd0, gpio_out}, 32'h11);
    bus_if.bus_wdata = 32'h22;
    @(negedge clk);
    check("b2b_gap", {31'd0, bus_if.bus_ready}, 32'd0);
    @(negedge clk);
    check("b2b_ready2", {31'd0, bus_if.bus_ready}, 32'd1);
    check("b2b_out2", {24'd0, gpio_out}, 32'h22);
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
    @(negedge clk);
    check("b2b_done", {31'd0, bus_if.bus_ready}, 32'd0);

    // IRQ
    gpio_in = 16'h0000;
    @(negedge clk);
    bus_write(5'h0C, 32'h0001_0001);
    bus_read(5'h10, rd);
    check("irq_stat0", rd, 32'h0);
    gpio_in = 16'h0001;
    @(negedge clk);
    check("irq_rise_irq", {31'd0, irq}, 32'd1);
    bus_read(5'h10, rd);
    check("irq_rise", rd, 32'h0000_0001);
    gpio_in = 16'h0000;
    @(negedge clk);
    bus_read(5'h10, rd);
    check("irq_fall", rd, 32'h0001_0001);
    bus_write(5'h10, 32'h0000_0001);
    bus_read(5'h10, rd);
    check("irq_w1c", rd, 32'h0001_0000);
    check("irq_still", {31'd0, irq}, 32'd1);
    // rise disabled, pending fall flag kept
    bus_write(5'h0C, 32'h0001_0000);
    gpio_in = 16'h0001;
    @(negedge clk);
    bus_read(5'h10, rd);
    check("irq_en_clr", rd, 32'h0001_0000);
    // W1C of the fall flag on the same edge as a new fall: set wins
    @(negedge clk);
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = 5'h10; bus_if.bus_wdata = 32'h0001_0000;
    gpio_in = 16'h0000;
    @(negedge clk);
    check("race_ready", {31'd0, bus_if.bus_ready}, 32'd1);
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
    bus_read(5'h10, rd);
    check("irq_race", rd, 32'h0001_0000);
    // plain clear drops irq in the RESP cycle
    @(negedge clk);
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = 5'h10; bus_if.bus_wdata = 32'h0001_0000;
    @(negedge clk);
    check("clr_irq_lo", {31'd0, irq}, 32'd0);
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
    // bit1 edge with enable 0
    gpio_in = 16'h0002;
    @(negedge clk);
    @(negedge clk);
    bus_read(5'h10, rd);
    check("irq_bit1_off", rd, 32'h0);
    check("irq_bit1_irq", {31'd0, irq}, 32'd0);

    // reset in the RESP cycle of a write
    @(negedge clk);
    bus_if.bus_sel = 1'b1; bus_if.bus_we = 1'b1; bus_if.bus_addr = 5'h00; bus_if.bus_wdata = 32'h77;
    @(posedge clk);
    #1;
    check("mid_out_pre", {24'd0, gpio_out}, 32'h77);
    check("mid_ready_pre", {31'd0, bus_if.bus_ready}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_out", {24'd0, gpio_out}, 32'h0);
    check("mid_ready", {31'd0, bus_if.bus_ready}, 32'd0);
    check("mid_dflt", {24'd0, dflt_st}, 32'd5);
    @(negedge clk);
    bus_if.bus_sel = 1'b0; bus_if.bus_we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, bus_if.bus_ready}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
